// File: rtl/axis_constant_multi.sv
// Multi-channel AXI-stream constant source: N_CONSTANTS value/dest channels programmed over AXI-lite,
// emitted as a batch on each sync pulse. Optional macro AXIS_CONSTANT_MULTI_LAST_EN drives tlast on the final beat.
module axis_constant_multi #(
    parameter int N_CONSTANTS    = 4,
    parameter int CONSTANT_WIDTH = 32,
    parameter int DEST_WIDTH     = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      sync,

    output logic                      const_out_valid,
    input  logic                      const_out_ready,
    output logic [CONSTANT_WIDTH-1:0] const_out_data,
    output logic [DEST_WIDTH-1:0]     const_out_dest,
    output logic                      const_out_last,

    input  logic [31:0]               axil_awaddr,
    input  logic                      axil_awvalid,
    output logic                      axil_awready,
    input  logic [31:0]               axil_wdata,
    input  logic [3:0]                axil_wstrb,
    input  logic                      axil_wvalid,
    output logic                      axil_wready,
    output logic [1:0]                axil_bresp,
    output logic                      axil_bvalid,
    input  logic                      axil_bready,
    input  logic [31:0]               axil_araddr,
    input  logic                      axil_arvalid,
    output logic                      axil_arready,
    output logic [31:0]               axil_rdata,
    output logic [1:0]                axil_rresp,
    output logic                      axil_rvalid,
    input  logic                      axil_rready
);

    // state | meaning
    // IDLE  | waiting for a sync pulse with something pending or auto-enabled
    // EMIT  | presenting the lowest remaining batch channel on const_out
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    localparam int IDX_W = (N_CONSTANTS > 1) ? $clog2(N_CONSTANTS) : 1;

    logic [31:0]            reg_low  [N_CONSTANTS];
    logic [31:0]            reg_high [N_CONSTANTS];
    logic [31:0]            reg_dest [N_CONSTANTS];
    logic [N_CONSTANTS-1:0] auto_mask;
    logic [N_CONSTANTS-1:0] pending;
    logic [N_CONSTANTS-1:0] batch;
    logic [0:0]             state;

    logic                   wr_en;
    logic                   rd_en;
    logic [27:0]            wr_blk;
    logic [1:0]             wr_off;
    logic [27:0]            rd_blk;
    logic [1:0]             rd_off;
    logic [31:0]            rd_word;
    logic [N_CONSTANTS-1:0] trig_bits;

    logic [N_CONSTANTS-1:0] snap;
    logic [IDX_W-1:0]       cur_idx;
    logic [N_CONSTANTS-1:0] batch_rem;
    logic [N_CONSTANTS-1:0] load_sel;
    logic [IDX_W-1:0]       load_idx;
    logic [N_CONSTANTS-1:0] load_rest;
    logic [63:0]            load_full;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_CONSTANTS-1:0] v);
        lowest_set = '0;
        for (int i = N_CONSTANTS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = IDX_W'(i);
        end
    endfunction

    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        strb_merge = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) strb_merge[8*b +: 8] = new_val[8*b +: 8];
        end
    endfunction

    // Write channel accepts address and data together, one outstanding response.
    assign wr_en        = axil_awvalid && axil_wvalid && !axil_bvalid;
    assign axil_awready = wr_en;
    assign axil_wready  = wr_en;
    assign axil_bresp   = 2'b00;
    assign rd_en        = axil_arvalid && !axil_rvalid;
    assign axil_arready = rd_en;
    assign axil_rresp   = 2'b00;

    assign wr_blk = axil_awaddr[31:4];
    assign wr_off = axil_awaddr[3:2];
    assign rd_blk = axil_araddr[31:4];
    assign rd_off = axil_araddr[3:2];

    assign trig_bits = (wr_en && wr_blk == 28'(N_CONSTANTS) && wr_off == 2'd0)
                       ? axil_wdata[N_CONSTANTS-1:0] : '0;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N_CONSTANTS; i++) begin
            if (rd_blk == 28'(i)) begin
                case (rd_off)
                    2'd0:    rd_word = reg_low[i];
                    2'd1:    rd_word = reg_high[i];
                    2'd2:    rd_word = reg_dest[i];
                    default: rd_word = '0;
                endcase
            end
        end
        if (rd_blk == 28'(N_CONSTANTS)) begin
            case (rd_off)
                2'd1:    rd_word[N_CONSTANTS-1:0] = auto_mask;
                2'd2:    rd_word[N_CONSTANTS:0]   = {state == ST_EMIT, pending};
                default: rd_word = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < N_CONSTANTS; i++) begin
                reg_low[i]  <= '0;
                reg_high[i] <= '0;
                reg_dest[i] <= '0;
            end
            auto_mask <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < N_CONSTANTS; i++) begin
                if (wr_blk == 28'(i)) begin
                    case (wr_off)
                        2'd0:    reg_low[i]  <= strb_merge(reg_low[i],  axil_wdata, axil_wstrb);
                        2'd1:    reg_high[i] <= strb_merge(reg_high[i], axil_wdata, axil_wstrb);
                        2'd2:    reg_dest[i] <= strb_merge(reg_dest[i], axil_wdata, axil_wstrb);
                        default: ;
                    endcase
                end
            end
            if (wr_blk == 28'(N_CONSTANTS) && wr_off == 2'd1) begin
                auto_mask <= axil_wdata[N_CONSTANTS-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            axil_bvalid <= 1'b0;
            axil_rvalid <= 1'b0;
            axil_rdata  <= '0;
        end else begin
            if (wr_en) begin
                axil_bvalid <= 1'b1;
            end else if (axil_bready) begin
                axil_bvalid <= 1'b0;
            end
            if (rd_en) begin
                axil_rvalid <= 1'b1;
                axil_rdata  <= rd_word;
            end else if (axil_rready) begin
                axil_rvalid <= 1'b0;
            end
        end
    end

    // A trigger write landing with sync is folded into the snapshot.
    always_comb begin
        snap                = pending | trig_bits | auto_mask;
        cur_idx             = lowest_set(batch);
        batch_rem           = batch;
        batch_rem[cur_idx]  = 1'b0;
        load_sel            = (state == ST_IDLE) ? snap : batch_rem;
        load_idx            = lowest_set(load_sel);
        load_rest           = load_sel;
        load_rest[load_idx] = 1'b0;
        load_full           = {reg_high[load_idx], reg_low[load_idx]};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= ST_IDLE;
            batch           <= '0;
            pending         <= '0;
            const_out_valid <= 1'b0;
            const_out_data  <= '0;
            const_out_dest  <= '0;
`ifdef AXIS_CONSTANT_MULTI_LAST_EN
            const_out_last  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sync && snap != '0) begin
                        batch           <= snap;
                        pending         <= '0;
                        const_out_valid <= 1'b1;
                        const_out_data  <= load_full[CONSTANT_WIDTH-1:0];
                        const_out_dest  <= reg_dest[load_idx][DEST_WIDTH-1:0];
`ifdef AXIS_CONSTANT_MULTI_LAST_EN
                        const_out_last  <= (load_rest == '0);
`endif
                        state           <= ST_EMIT;
                    end else begin
                        pending <= pending | trig_bits;
                    end
                end
                ST_EMIT: begin
                    // Sync is ignored here; triggers wait in pending for the next slot.
                    pending <= pending | trig_bits;
                    if (const_out_valid && const_out_ready) begin
                        batch <= batch_rem;
                        if (batch_rem == '0) begin
                            const_out_valid <= 1'b0;
                            state           <= ST_IDLE;
                        end else begin
                            const_out_data  <= load_full[CONSTANT_WIDTH-1:0];
                            const_out_dest  <= reg_dest[load_idx][DEST_WIDTH-1:0];
`ifdef AXIS_CONSTANT_MULTI_LAST_EN
                            const_out_last  <= (load_rest == '0);
`endif
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef AXIS_CONSTANT_MULTI_LAST_EN
    assign const_out_last = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{axil_awaddr[1:0], axil_araddr[1:0], load_full, load_rest};

endmodule
